// File: rtl/uart_receiver_pkg.sv
// Shared UART timing constants and the 3-bit receive state encodings.
package uart_receiver_pkg;
  localparam int CLKS_PER_BIT      = 16;
  localparam int CLOCK_COUNT_WIDTH = 8;

  typedef enum logic [2:0] {
    s_IDLE         = 3'd0,
    s_RX_START_BIT = 3'd1,
    s_RX_DATA_BITS = 3'd2,
    s_RX_STOP_BIT  = 3'd3,
    s_CLEANUP      = 3'd4,
    s_WAIT_HIGH    = 3'd5
  } rx_state_e;
endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial pin; resets to the idle (high) level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_receiver.sv
// 8-N-1 UART receiver sampling each bit at mid-period.
// Define UART_RX_FRAME_ERR_EN to flag stop-bit errors and hold off until the line returns high.
module uart_receiver
  import uart_receiver_pkg::*;
(
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Active,
  output logic       o_Rx_Frame_Err
);
  localparam int CW = CLOCK_COUNT_WIDTH;
  localparam int N  = CLKS_PER_BIT;
  localparam int H  = (N - 1) / 2;
  localparam logic [CW-1:0] CNT_LAST   = CW'(N - 1);
  // detect cycle plus H-1 more lands the start re-sample H cycles after detection
  localparam logic [CW-1:0] START_LAST = CW'(H - 1);

  rx_state_e       state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [2:0]      idx, idx_nxt;
  logic [7:0]      shf, shf_nxt;
  logic [7:0]      byte_q, byte_nxt;
  logic            dv, dv_nxt;
  logic            act, act_nxt;
  logic            rx;
`ifdef UART_RX_FRAME_ERR_EN
  logic            ferr, ferr_nxt;
`endif

  uart_rx_sync u_sync (
    .clk (i_Clock),
    .rst (i_Reset),
    .d   (i_Rx_Serial),
    .q   (rx)
  );

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state  <= s_IDLE;
      cnt    <= '0;
      idx    <= '0;
      shf    <= '0;
      byte_q <= '0;
      dv     <= 1'b0;
      act    <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      ferr   <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      idx    <= idx_nxt;
      shf    <= shf_nxt;
      byte_q <= byte_nxt;
      dv     <= dv_nxt;
      act    <= act_nxt;
`ifdef UART_RX_FRAME_ERR_EN
      ferr   <= ferr_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    shf_nxt   = shf;
    byte_nxt  = byte_q;
    dv_nxt    = 1'b0;
    act_nxt   = act;
`ifdef UART_RX_FRAME_ERR_EN
    ferr_nxt  = 1'b0;
`endif
    case (state)
      s_IDLE: begin
        if (!rx) begin
          cnt_nxt   = '0;
          idx_nxt   = '0;
          act_nxt   = 1'b1;
          state_nxt = s_RX_START_BIT;
        end
      end
      s_RX_START_BIT: begin
        if (cnt == START_LAST) begin
          cnt_nxt = '0;
          if (!rx) begin
            state_nxt = s_RX_DATA_BITS;
          end else begin
            act_nxt   = 1'b0;
            state_nxt = s_IDLE;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      s_RX_DATA_BITS: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt      = '0;
          shf_nxt[idx] = rx;
          if (idx == 3'd7) state_nxt = s_RX_STOP_BIT;
          else             idx_nxt   = idx + 3'd1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      s_RX_STOP_BIT: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt = '0;
          act_nxt = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
          if (rx) begin
            byte_nxt  = shf;
            dv_nxt    = 1'b1;
            state_nxt = s_CLEANUP;
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = s_WAIT_HIGH;
          end
`else
          byte_nxt  = shf;
          dv_nxt    = 1'b1;
          state_nxt = s_CLEANUP;
`endif
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      s_CLEANUP:   state_nxt = s_IDLE;
      // a held-low line (break) must return high before another start is accepted
      s_WAIT_HIGH: if (rx) state_nxt = s_IDLE;
      default:     state_nxt = s_IDLE;
    endcase
  end

  assign o_Rx_DV     = dv;
  assign o_Rx_Byte   = byte_q;
  assign o_Rx_Active = act;
`ifdef UART_RX_FRAME_ERR_EN
  assign o_Rx_Frame_Err = ferr;
`else
  assign o_Rx_Frame_Err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: directed frames, glitch, stop-bit error, break and mid-frame reset.
module tb_uart_receiver;
  localparam int N   = uart_receiver_pkg::CLKS_PER_BIT;
  // 2 cycles of synchronizer delay to detection, then H + 9N + 1 = 152 for N=16
  localparam int LAT = 154;

  typedef struct {
    logic [1:0] kind;   // 1 = DV, 2 = frame error
    logic [7:0] data;   // expected o_Rx_Byte at the pulse
    int         t0;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       dv, active, ferr;
  logic [7:0] rbyte;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  logic [7:0] last_byte = 8'h00;

  uart_receiver dut (
    .i_Clock        (clk),
    .i_Reset        (rst),
    .i_Rx_Serial    (rx),
    .o_Rx_DV        (dv),
    .o_Rx_Byte      (rbyte),
    .o_Rx_Active    (active),
    .o_Rx_Frame_Err (ferr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    tick(N);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(N);
    end
    rx = stop_bit;
    tick(N);
    rx = 1'b1;
  endtask

  task automatic frame(input logic [7:0] b, input logic stop_bit, input logic [1:0] kind);
    exp_t e;
    e.kind = kind;
    e.t0   = cyc;
    if (kind == 2'd1) begin
      e.data    = b;
      last_byte = b;
    end else begin
      e.data = last_byte;
    end
    sb.push_back(e);
    send(b, stop_bit);
  endtask

  // monitor: every DV / error pulse must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && (dv || ferr)) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pulse: got dv=%0b err=%0b byte=%0h expected no pulse", dv, ferr, rbyte);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_kind", {30'd0, ferr, dv}, {30'd0, e.kind});
        chk("rx_byte", {24'd0, rbyte}, {24'd0, e.data});
        chk("latency", cyc - e.t0, LAT);
      end
    end
  end

  initial begin
    tick(3);
    chk("rst_dv", {31'd0, dv}, 0);
    chk("rst_byte", {24'd0, rbyte}, 0);
    chk("rst_active", {31'd0, active}, 0);
    chk("rst_ferr", {31'd0, ferr}, 0);
    rst = 1'b0;
    tick(5);

    frame(8'hA5, 1'b1, 2'd1);
    tick(10);

    frame(8'h00, 1'b1, 2'd1);
    frame(8'hFF, 1'b1, 2'd1);
    tick(20);

    // 3-cycle glitch: active rises, then drops at the start re-sample
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(2);
    chk("glitch_active_hi", {31'd0, active}, 1);
    tick(20);
    chk("glitch_active_lo", {31'd0, active}, 0);
    chk("glitch_byte", {24'd0, rbyte}, {24'd0, last_byte});

`ifdef UART_RX_FRAME_ERR_EN
    frame(8'h3C, 1'b0, 2'd2);
`else
    frame(8'h3C, 1'b0, 2'd1);
`endif
    tick(30);

`ifdef UART_RX_FRAME_ERR_EN
    begin
      exp_t e;
      e.kind = 2'd2;
      e.data = last_byte;
      e.t0   = cyc;
      sb.push_back(e);
      rx = 1'b0;
      tick(40 * N);
      chk("break_active", {31'd0, active}, 0);
      rx = 1'b1;
      tick(20);
      frame(8'h55, 1'b1, 2'd1);
      tick(10);
    end
`endif

    // reset in data bit 4 of 0x81; line released high together with reset
    rx = 1'b0;
    tick(N);
    for (int i = 0; i < 4; i++) begin
      rx = (8'h81 >> i) & 8'h01;
      tick(N);
    end
    rx = 1'b0;
    tick(5);
    chk("pre_rst_active", {31'd0, active}, 1);
    rst = 1'b1;
    rx  = 1'b1;
    tick(1);
    chk("midrst_dv", {31'd0, dv}, 0);
    chk("midrst_byte", {24'd0, rbyte}, 0);
    chk("midrst_active", {31'd0, active}, 0);
    chk("midrst_ferr", {31'd0, ferr}, 0);
    rst = 1'b0;
    last_byte = 8'h00;
    tick(30);
    chk("post_rst_active", {31'd0, active}, 0);
    frame(8'h42, 1'b1, 2'd1);

    for (int i = 0; i < 500 && sb.size() != 0; i++) tick(1);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending pulses expected 0", sb.size());
    end
    tick(10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL use compile-time constant `CLKS_PER_BIT`, which is codebase-global and has no local default; it is clock cycles per serial bit and SHALL be at least 4.
REQ-002 SHALL use compile-time constant `CLOCK_COUNT_WIDTH`, which is codebase-global and has no local default; it is the width of the bit-period counter.
REQ-003 i_Clock  input  1  sole clock; all logic on posedge.
REQ-004 i_Reset  input  1  synchronous, active-high reset.
REQ-005 i_Rx_Serial  input  1  asynchronous serial line from the FPGA pin; idles high.
REQ-006 o_Rx_DV  output  1  one-cycle pulse when o_Rx_Byte holds a newly received byte.
REQ-007 o_Rx_Byte  output  8  last received byte, LSB first on the wire.
REQ-008 o_Rx_Active  output  1  high while a frame is being received.
REQ-009 o_Rx_Frame_Err  output  1  one-cycle pulse when a sampled stop bit is 0.

Function
REQ-010 SHALL decode 8-N-1 frames: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
REQ-011 i_Rx_Serial SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value.
REQ-012 Define N = `CLKS_PER_BIT and H = (N-1)/2, truncated.
REQ-013 The state machine SHALL have the states s_IDLE, s_RX_START_BIT, s_RX_DATA_BITS, s_RX_STOP_BIT, s_CLEANUP and s_WAIT_HIGH.
REQ-014 s_IDLE: when the synchronized line is 0, SHALL clear the counter, set o_Rx_Active, and go to s_RX_START_BIT.
REQ-015 s_RX_START_BIT: after H further cycles, SHALL re-sample the line.
- If the line is 0, SHALL clear the counter and go to s_RX_DATA_BITS.
- If the line is 1, it is a glitch: SHALL clear o_Rx_Active and return to s_IDLE without pulsing DV.
REQ-016 s_RX_DATA_BITS: SHALL sample every N cycles, at mid-bit, into bit index 0..7, then go to s_RX_STOP_BIT.
REQ-017 s_RX_STOP_BIT: SHALL sample N cycles after the last data bit.
REQ-018 On a stop bit of 1, SHALL load o_Rx_Byte, pulse o_Rx_DV for exactly one cycle, clear o_Rx_Active, and go to s_CLEANUP.
REQ-019 s_CLEANUP: SHALL last exactly 1 cycle, then go to s_IDLE.
REQ-020 Latency: o_Rx_DV SHALL assert H + 9N + 1 cycles after the cycle in which s_IDLE detects the low line.
REQ-021 o_Rx_Byte SHALL hold its value until the next valid frame; a glitch or framing error SHALL NOT change it.
REQ-022 A new start bit arriving immediately after s_CLEANUP SHALL be accepted, so back-to-back frames need no idle gap.
REQ-023 The counter SHALL count 0..N-1 and never wrap beyond it; the bit index SHALL saturate at 7.

Reset
REQ-024 With i_Reset high at a clock edge, next state:
- o_Rx_DV = 0
- o_Rx_Byte = 8'h00
- o_Rx_Active = 0
- o_Rx_Frame_Err = 0
- state = s_IDLE
- counter = 0
- bit index = 0
- both synchronizer flops = 1
REQ-025 Reset mid-frame SHALL abandon the frame with no DV or error pulse; reception SHALL restart only on the next falling edge after reset release.
REQ-026 Reset SHALL take priority over all other state transitions.

Configuration
REQ-027 Macro UART_RX_FRAME_ERR_EN.
REQ-028 Defined: a stop bit of 0 SHALL pulse o_Rx_Frame_Err for 1 cycle instead of o_Rx_DV, clear o_Rx_Active, and go to s_WAIT_HIGH.
REQ-029 s_WAIT_HIGH SHALL stay until the synchronized line is 1, then go to s_IDLE, so that a break is not re-received as frames.
REQ-030 Undefined: the stop bit SHALL be ignored, o_Rx_DV SHALL pulse and o_Rx_Byte SHALL load regardless, o_Rx_Frame_Err SHALL be tied 0, and s_WAIT_HIGH SHALL be unreachable.

Structure
REQ-031 The shared package/header SHALL hold `CLKS_PER_BIT`, `CLOCK_COUNT_WIDTH` and the 3-bit RX state encodings.
REQ-032 The 2-flop synchronizer SHALL be sub-module uart_rx_sync, which has a reset value of 1.
REQ-033 The receiver SHALL be instantiable alongside uart_transmitter with an identical bit timing.

Verification (bench N=16, H=7)
REQ-034 Receive frame 0xA5 -> o_Rx_DV pulses once, o_Rx_Byte = 8'hA5, pulse at detect + 152 cycles (7 + 144 + 1).
REQ-035 Back-to-back frames 0x00 then 0xFF, no gap -> two DV pulses with bytes 8'h00 and 8'hFF in order, and no frame error.
REQ-036 Line low for 3 cycles, then high -> no DV pulse, o_Rx_Active returns to 0, o_Rx_Byte unchanged.
REQ-037 Frame 0x3C with stop bit 0:
- With UART_RX_FRAME_ERR_EN: o_Rx_Frame_Err pulses, no DV, o_Rx_Byte unchanged.
- Without it: DV pulses with 8'h3C.
REQ-038 Break, i.e. line held low for 40N -> with the macro: exactly one Frame_Err, no further activity until the line goes high, then 0x55 is received correctly.
REQ-039 i_Reset asserted during data bit 4 of frame 0x81 -> all outputs 0 next cycle, no DV, next frame 0x42 is received correctly.
